bcd_counter_chain: RTL and testbench

BCD_COUNTER_CHAIN -- requirements
Module: bcd_counter_chain

---
 rtl/bcd_counter_chain_pkg.sv | 16 +
 rtl/bcd_counter_chain_digit.sv | 50 +++++
 rtl/bcd_counter_chain.sv | 120 ++++++++++++
 tb/tb_bcd_counter_chain.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants and FSM encoding for the cascaded BCD counter chain.
package bcd_counter_chain_pkg;

  localparam int unsigned BCD_BIT_WIDTH = 4;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  localparam logic [BCD_BIT_WIDTH-1:0] ONE = BCD_BIT_WIDTH'(1);

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StDone = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// One BCD digit: counts up/down between 0 and its limit, with a wrap-out
// flag that enables the next-higher digit.
module bcd_digit
  import bcd_counter_chain_pkg::*;
#(
  parameter int unsigned DIGIT_W = BCD_BIT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] rst_value,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic               en,
  input  logic               down,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] q,
  output logic               wrap
);

  logic [DIGIT_W-1:0] q_q, q_d;
  logic               at_edge;

  // A digit sitting at its end value wraps and carries/borrows onward.
  assign at_edge = down ? (q_q == '0) : (q_q == limit);
  assign wrap    = en & at_edge;

  always_comb begin
    q_d = q_q;
    if (load == ENABLED) begin
      q_d = load_value;
    end else if (en == ENABLED) begin
      if (down) begin
        q_d = at_edge ? limit : q_q - ONE;
      end else begin
        q_d = at_edge ? '0 : q_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= rst_value;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded BCD counter with per-digit limits, whole-chain terminal handling,
// wrap/saturate modes and a RUN/DONE state machine.
module bcd_counter_chain
  import bcd_counter_chain_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = BCD_BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          count_enable,
  input  logic                          count_down,
  input  logic                          sat_mode,
  input  logic                          load_enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] initial_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digit_limit,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] terminal_value,
  output logic [NUM_DIGITS*DIGIT_W-1:0] q,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic                          done
);

  localparam int unsigned W = NUM_DIGITS * DIGIT_W;

  state_e         state_q, state_d;
  logic           carry_q, carry_d;
  logic           borrow_q, borrow_d;
  logic           step;
  logic           chain_load;
  logic [W-1:0]   chain_load_value;
  logic [W-1:0]   clamped_load;
  logic [NUM_DIGITS:0] en_chain;
  logic           at_terminal, at_zero;

  assign at_terminal = (q == terminal_value);
  assign at_zero     = (q == '0);

  always_comb begin
    clamped_load = load_value;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (load_value[i*DIGIT_W +: DIGIT_W] > digit_limit[i*DIGIT_W +: DIGIT_W]) begin
        clamped_load[i*DIGIT_W +: DIGIT_W] = digit_limit[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Priority: load, then terminal handling, then ordinary counting.
  always_comb begin
    state_d          = state_q;
    carry_d          = DISABLED;
    borrow_d         = DISABLED;
    step             = DISABLED;
    chain_load       = DISABLED;
    chain_load_value = clamped_load;
    if (load_enable == ENABLED) begin
      chain_load = ENABLED;
      state_d    = StRun;
    end else if (state_q == StDone) begin
      if (!sat_mode) state_d = StRun;
    end else if (count_enable == ENABLED) begin
      if (!count_down && at_terminal) begin
        if (sat_mode) begin
          state_d = StDone;
        end else begin
          chain_load       = ENABLED;
          chain_load_value = initial_value;
          carry_d          = ENABLED;
        end
      end else if (count_down && at_zero) begin
        if (sat_mode) begin
          state_d = StDone;
        end else begin
          chain_load       = ENABLED;
          chain_load_value = terminal_value;
          borrow_d         = ENABLED;
        end
      end else begin
        step = ENABLED;
      end
    end
  end

  assign en_chain[0] = step;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .DIGIT_W(DIGIT_W)
    ) u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .rst_value (initial_value[i*DIGIT_W +: DIGIT_W]),
      .load      (chain_load),
      .load_value(chain_load_value[i*DIGIT_W +: DIGIT_W]),
      .en        (en_chain[i]),
      .down      (count_down),
      .limit     (digit_limit[i*DIGIT_W +: DIGIT_W]),
      .q         (q[i*DIGIT_W +: DIGIT_W]),
      .wrap      (en_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      carry_q  <= DISABLED;
      borrow_q <= DISABLED;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed self-checking bench for bcd_counter_chain (4 digits, HH:MM-like limits).
module tb_bcd_counter_chain;

  logic        clk;
  logic        rst_n;
  logic        count_enable;
  logic        count_down;
  logic        sat_mode;
  logic        load_enable;
  logic [15:0] load_value;
  logic [15:0] initial_value;
  logic [15:0] digit_limit;
  logic [15:0] terminal_value;
  logic [15:0] q;
  logic        carry_out;
  logic        borrow_out;
  logic        done;

  int checks;
  int errors;

  bcd_counter_chain #(
    .NUM_DIGITS(4),
    .DIGIT_W   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_enable  (count_enable),
    .count_down    (count_down),
    .sat_mode      (sat_mode),
    .load_enable   (load_enable),
    .load_value    (load_value),
    .initial_value (initial_value),
    .digit_limit   (digit_limit),
    .terminal_value(terminal_value),
    .q             (q),
    .carry_out     (carry_out),
    .borrow_out    (borrow_out),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    count_enable = 1'b0;
    load_enable  = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    load_enable  = 1'b1;
    count_enable = 1'b0;
    load_value   = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (q !== 16'h0000 || carry_out !== 1'b0 || borrow_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%h c=%b b=%b d=%b required q=0000 c=0 b=0 d=0",
               q, carry_out, borrow_out, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_digit_cascade();
    load(16'h0959);
    count_down   = 1'b0;
    count_enable = 1'b1;
    tick();
    idle();
    checks++;
    if (q !== 16'h1000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL cascade: q=%h c=%b required q=1000 c=0", q, carry_out);
    end
  endtask

  task automatic test_up_wrap();
    sat_mode = 1'b0;
    load(16'h2359);
    count_down   = 1'b0;
    count_enable = 1'b1;
    tick();
    idle();
    checks++;
    if (q !== 16'h0000 || carry_out !== 1'b1 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap: q=%h c=%b b=%b required q=0000 c=1 b=0", q, carry_out, borrow_out);
    end
    tick();
    checks++;
    if (q !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap_pulse: q=%h c=%b required q=0000 c=0", q, carry_out);
    end
  endtask

  task automatic test_down_wrap();
    sat_mode = 1'b0;
    load(16'h0000);
    count_down   = 1'b1;
    count_enable = 1'b1;
    tick();
    checks++;
    if (q !== 16'h2359 || borrow_out !== 1'b1 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap: q=%h b=%b c=%b required q=2359 b=1 c=0", q, borrow_out, carry_out);
    end
    tick();
    idle();
    checks++;
    if (q !== 16'h2358 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL down_step: q=%h b=%b required q=2358 b=0", q, borrow_out);
    end
    load(16'h1200);
    count_enable = 1'b1;
    tick();
    idle();
    checks++;
    if (q !== 16'h1159) begin
      errors++;
      $display("FAIL down_borrow_digits: q=%h required 1159", q);
    end
  endtask

  task automatic test_saturate();
    sat_mode = 1'b1;
    load(16'h2359);
    count_down   = 1'b0;
    count_enable = 1'b1;
    repeat (3) tick();
    idle();
    checks++;
    if (q !== 16'h2359 || done !== 1'b1 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: q=%h d=%b c=%b required q=2359 d=1 c=0", q, done, carry_out);
    end
    load(16'h1200);
    checks++;
    if (q !== 16'h1200 || done !== 1'b0) begin
      errors++;
      $display("FAIL sat_load_exit: q=%h d=%b required q=1200 d=0", q, done);
    end
    // Down-terminal saturation, then leave DONE by dropping sat_mode.
    load(16'h0000);
    count_down   = 1'b1;
    count_enable = 1'b1;
    tick();
    checks++;
    if (q !== 16'h0000 || done !== 1'b1 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL sat_down: q=%h d=%b b=%b required q=0000 d=1 b=0", q, done, borrow_out);
    end
    sat_mode = 1'b0;
    tick();
    idle();
    checks++;
    if (done !== 1'b0 || q !== 16'h0000) begin
      errors++;
      $display("FAIL sat_exit: q=%h d=%b required q=0000 d=0", q, done);
    end
  endtask

  task automatic test_load_priority();
    sat_mode = 1'b0;
    load(16'h2359);
    count_down   = 1'b0;
    count_enable = 1'b1;
    load_enable  = 1'b1;
    load_value   = 16'h1111;
    tick();
    idle();
    checks++;
    if (q !== 16'h1111 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL load_priority: q=%h c=%b required q=1111 c=0", q, carry_out);
    end
    load(16'h0969);
    checks++;
    if (q !== 16'h0959) begin
      errors++;
      $display("FAIL load_clamp: q=%h required 0959", q);
    end
    load(16'h9999);
    checks++;
    if (q !== 16'h2959) begin
      errors++;
      $display("FAIL load_clamp_all: q=%h required 2959", q);
    end
  endtask

  task automatic test_hold_and_direction();
    load(16'h0009);
    repeat (2) tick();
    checks++;
    if (q !== 16'h0009 || carry_out !== 1'b0 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL hold: q=%h c=%b b=%b required q=0009 c=0 b=0", q, carry_out, borrow_out);
    end
    count_enable = 1'b1;
    count_down   = 1'b0;
    tick();
    checks++;
    if (q !== 16'h0010) begin
      errors++;
      $display("FAIL dir_up: q=%h required 0010", q);
    end
    count_down = 1'b1;
    tick();
    checks++;
    if (q !== 16'h0009) begin
      errors++;
      $display("FAIL dir_down: q=%h required 0009", q);
    end
    count_down = 1'b0;
    tick();
    idle();
    checks++;
    if (q !== 16'h0010) begin
      errors++;
      $display("FAIL dir_up_again: q=%h required 0010", q);
    end
  endtask

  task automatic test_async_reset();
    sat_mode = 1'b0;
    load(16'h1233);
    count_down   = 1'b0;
    count_enable = 1'b1;
    tick();
    checks++;
    if (q !== 16'h1234) begin
      errors++;
      $display("FAIL pre_reset: q=%h required 1234", q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 16'h0000 || carry_out !== 1'b0 || borrow_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h c=%b b=%b d=%b required q=0000 c=0 b=0 d=0",
               q, carry_out, borrow_out, done);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    count_enable = 1'b1;
    tick();
    idle();
    checks++;
    if (q !== 16'h0001) begin
      errors++;
      $display("FAIL resume: q=%h required 0001", q);
    end
    // Reset held across an edge that would otherwise wrap must leave no pulse.
    load(16'h2359);
    count_enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (q !== 16'h0000 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: q=%h c=%b required q=0000 c=0", q, carry_out);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    count_enable   = 1'b0;
    count_down     = 1'b0;
    sat_mode       = 1'b0;
    load_enable    = 1'b0;
    load_value     = 16'h0000;
    initial_value  = 16'h0000;
    digit_limit    = 16'h2959;
    terminal_value = 16'h2359;

    test_reset();
    test_digit_cascade();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_hold_and_direction();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
